rnd_arb: RTL and testbench

Shared rounding scheduler: arbitrates NREQ requesters onto a single round-half-up rounding datapath (drop DW_RND LSBs, add back bit DW_RND-1) with a round-robin grant. Each accepted operand is rounded and registered into a one-deep output stage tagged with the requester index. Sits between multiple filter/accumulator lanes and the downstream narrow-width consumer, replacing per-lane rounders.

---
 rtl/rnd_arb_pkg.sv | 35 +++
 rtl/rnd_rr_pick.sv | 33 +++
 rtl/rnd_arb.sv | 71 +++++++
 tb/tb_rnd_arb.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rnd_arb_pkg.sv
// Shared configuration, rounding function and sizing helper for the rnd_arb
// round-robin rounding scheduler.
package rnd_arb_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  localparam int unsigned NREQ   = 4;
  localparam int unsigned DW_IN  = 10;
  localparam int unsigned DW_RND = 2;
  localparam int unsigned DW_OUT = DW_IN - DW_RND;
  localparam int unsigned DW_R   = DW_OUT + 1;
  localparam int unsigned IDW    = clog2(NREQ);

  typedef struct packed {
    logic              ovf;
    logic [DW_OUT-1:0] res;
  } rnd_res_t;

  // Round-half-up: drop DW_RND LSBs and add back the MSB of the dropped part.
  // The carry-out flags a wrap to zero; there is no saturation.
  function automatic rnd_res_t rnd_op(input logic [DW_IN-1:0] din);
    logic [DW_R-1:0] r;
    rnd_res_t        o;
    r     = {1'b0, din[DW_IN-1:DW_RND]} + DW_R'(din[DW_RND-1]);
    o.ovf = r[DW_OUT];
    o.res = r[DW_OUT-1:0];
    return o;
  endfunction

endpackage

// File: rtl/rnd_rr_pick.sv
// Combinational round-robin picker: first valid requester after ptr, wrapping.
module rnd_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] vld,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant_c,
  output logic [IDW-1:0]  idx_c,
  output logic            any_c
);

  int unsigned    k;
  logic [IDW-1:0] k_idx;

  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    k       = 0;
    k_idx   = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      k     = (32'(ptr) + off) % NREQ;
      k_idx = IDW'(k);
      if (!any_c && vld[k_idx]) begin
        any_c          = 1'b1;
        idx_c          = k_idx;
        grant_c[k_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rnd_arb.sv
// Round-robin scheduler sharing one round-half-up datapath across NREQ lanes,
// with a one-deep registered output stage tagged by requester id.
module rnd_arb
  import rnd_arb_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NREQ-1:0]       i_req_vld,
  input  logic [NREQ*DW_IN-1:0] i_req_din,
  output logic [NREQ-1:0]       o_req_rdy,
  output logic                  o_vld,
  output logic [DW_OUT-1:0]     o_dout,
  output logic [IDW-1:0]        o_id,
  output logic                  o_ovf,
  input  logic                  i_rdy
);

  logic [IDW-1:0]   ptr;
  logic [NREQ-1:0]  grant_c;
  logic [IDW-1:0]   win_c;
  logic             any_c;
  logic             can_accept_c;
  logic             xfer_c;
  logic [DW_IN-1:0] din_sel_c;
  rnd_res_t         rnd_c;

  rnd_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .vld     (i_req_vld),
    .ptr     (ptr),
    .grant_c (grant_c),
    .idx_c   (win_c),
    .any_c   (any_c)
  );

  // Output register is free if empty or being drained this cycle.
  assign can_accept_c = ~o_vld | i_rdy;
  assign o_req_rdy    = grant_c & {NREQ{can_accept_c & i_rst_n}};
  assign xfer_c       = any_c & can_accept_c;

  always_comb begin
    din_sel_c = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      din_sel_c = din_sel_c | (i_req_din[k*DW_IN +: DW_IN] & {DW_IN{grant_c[k]}});
    end
  end

  assign rnd_c = rnd_op(din_sel_c);

  // Priority pointer only moves on a transfer; a drain alone leaves data held.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr    <= IDW'(NREQ - 1);
      o_vld  <= 1'b0;
      o_dout <= '0;
      o_id   <= '0;
      o_ovf  <= 1'b0;
    end else if (xfer_c) begin
      ptr    <= win_c;
      o_vld  <= 1'b1;
      o_dout <= rnd_c.res;
      o_id   <= win_c;
      o_ovf  <= rnd_c.ovf;
    end else if (i_rdy) begin
      o_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rnd_arb.sv
// Self-checking bench for rnd_arb: rounding vector table, directed arbitration
// sequences and a random run against a cycle-level reference model.
module tb_rnd_arb;
  import rnd_arb_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_vld;
  logic [NREQ*DW_IN-1:0] req_din;
  logic [NREQ-1:0]       req_rdy;
  logic                  vld;
  logic [DW_OUT-1:0]     dout;
  logic [IDW-1:0]        id;
  logic                  ovf;
  logic                  rdy;

  int checks = 0;
  int errors = 0;

  rnd_arb dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req_vld (req_vld),
    .i_req_din (req_din),
    .o_req_rdy (req_rdy),
    .o_vld     (vld),
    .o_dout    (dout),
    .o_id      (id),
    .o_ovf     (ovf),
    .i_rdy     (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned din;
    int unsigned dout;
    int unsigned ovf;
  } rnd_vec_t;

  typedef struct {
    int unsigned id;
    int unsigned dout;
    int unsigned ovf;
  } sb_ent_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_din(input int k, input int unsigned v);
    req_din[k*DW_IN +: DW_IN] = DW_IN'(v);
  endtask

  // Reference rounding: floor((din + half_lsb) / 2^DW_RND), wrap beyond DW_OUT bits.
  function automatic void ref_round(input int unsigned din, output int unsigned d,
                                    output int unsigned o);
    int unsigned r;
    r = (din + (32'd1 << (DW_RND - 1))) / (32'd1 << DW_RND);
    o = (r >= (32'd1 << DW_OUT)) ? 1 : 0;
    d = r % (32'd1 << DW_OUT);
  endfunction

  // Reference arbitration: scan requesters in order ptr+1, ptr+2, ... (mod NREQ).
  function automatic int ref_pick(input logic [NREQ-1:0] v, input int p);
    int order[$];
    for (int i = 1; i <= int'(NREQ); i++) order.push_back((p + i) % int'(NREQ));
    foreach (order[i]) if (v[order[i]]) return order[i];
    return -1;
  endfunction

  rnd_vec_t tv[$];

  int          m_ptr;
  bit          m_vld;
  int unsigned m_dout, m_id, m_ovf;
  sb_ent_t     sbq[$];

  initial begin
    int unsigned ed, eo, din_v;
    int          w;
    bit          can, acc;
    sb_ent_t     e;

    tv.push_back('{32'h0FE, 32'h40, 0});
    tv.push_back('{32'h005, 32'h01, 0});
    tv.push_back('{32'h3FE, 32'h00, 1});
    tv.push_back('{32'h3FF, 32'h00, 1});
    tv.push_back('{32'h3FB, 32'hFF, 0});
    tv.push_back('{32'h3FC, 32'hFF, 0});
    tv.push_back('{32'h001, 32'h00, 0});
    tv.push_back('{32'h002, 32'h01, 0});

    rst_n = 1'b0; req_vld = '0; req_din = '0; rdy = 1'b0;
    #12;
    chk("rst_vld", 32'(vld), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_id", 32'(id), 0);
    chk("rst_ovf", 32'(ovf), 0);
    req_vld = '1;
    #1 chk("rst_req_rdy", 32'(req_rdy), 0);
    req_vld = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Rounding vector table, all through requester 0
    rdy = 1'b1;
    foreach (tv[i]) begin
      set_din(0, tv[i].din);
      req_vld = 4'b0001;
      #1 chk("rnd_req_rdy", 32'(req_rdy), 1);
      tick();
      req_vld = '0;
      chk("rnd_vld", 32'(vld), 1);
      chk("rnd_dout", 32'(dout), tv[i].dout);
      chk("rnd_ovf", 32'(ovf), tv[i].ovf);
      chk("rnd_id", 32'(id), 0);
    end

    // Reset asserted mid-stream while a result is stalled
    set_din(0, 32'h0FE); req_vld = 4'b0001; rdy = 1'b1;
    tick();
    set_din(0, 32'h005); rdy = 1'b0;
    tick();
    chk("stall_vld", 32'(vld), 1);
    chk("stall_dout", 32'(dout), 32'h40);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(vld), 0);
    chk("mid_rst_dout", 32'(dout), 0);
    chk("mid_rst_id", 32'(id), 0);
    chk("mid_rst_ovf", 32'(ovf), 0);
    chk("mid_rst_req_rdy", 32'(req_rdy), 0);
    tick();
    chk("mid_rst_hold", 32'(vld), 0);
    rst_n = 1'b1; req_vld = '0; rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_empty", 32'(vld), 0);
    end

    // Fairness: all requesters valid, results 0,1,2,3,0,1 back to back
    for (int k = 0; k < int'(NREQ); k++) set_din(k, 32'(k + 1) * 32'h44 + 32'h2);
    req_vld = '1;
    for (int i = 0; i < 6; i++) begin
      tick();
      ref_round(32'((i % 4) + 1) * 32'h44 + 32'h2, ed, eo);
      chk("rr_vld", 32'(vld), 1);
      chk("rr_id", 32'(id), 32'(i % 4));
      chk("rr_dout", 32'(dout), ed);
    end
    req_vld = '0;

    // Priority memory: grant 2, idle, then 1 and 3 together -> 3 first
    req_vld = 4'b0100;
    #1 chk("pm_req_rdy2", 32'(req_rdy), 32'b0100);
    tick();
    req_vld = '0;
    chk("pm_id2", 32'(id), 2);
    for (int i = 0; i < 3; i++) tick();
    chk("pm_idle_vld", 32'(vld), 0);
    req_vld = 4'b1010;
    #1 chk("pm_req_rdy3", 32'(req_rdy), 32'b1000);
    tick();
    chk("pm_id3", 32'(id), 3);
    req_vld = 4'b0010;
    #1 chk("pm_req_rdy1", 32'(req_rdy), 32'b0010);
    tick();
    req_vld = '0;
    chk("pm_id1", 32'(id), 1);
    tick();

    // Back-pressure: 5 stalled cycles, then drain and accept with no bubble
    set_din(0, 32'h0FE); req_vld = 4'b0001; rdy = 1'b0;
    tick();
    set_din(1, 32'h005); req_vld = 4'b0010;
    chk("bp_load_id", 32'(id), 0);
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_req_rdy", 32'(req_rdy), 0);
      tick();
      chk("bp_vld", 32'(vld), 1);
      chk("bp_id", 32'(id), 0);
      chk("bp_dout", 32'(dout), 32'h40);
    end
    rdy = 1'b1;
    #1 chk("bp_release_rdy", 32'(req_rdy), 32'b0010);
    tick();
    req_vld = '0;
    chk("bp_next_vld", 32'(vld), 1);
    chk("bp_next_id", 32'(id), 1);
    chk("bp_next_dout", 32'(dout), 1);
    tick();
    chk("bp_drained", 32'(vld), 0);

    // Random stress against the reference model
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_ptr = int'(NREQ) - 1; m_vld = 0; m_dout = 0; m_id = 0; m_ovf = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("rs_vld", 32'(vld), 32'(m_vld));
      chk("rs_dout", 32'(dout), m_dout);
      chk("rs_id", 32'(id), m_id);
      chk("rs_ovf", 32'(ovf), m_ovf);
      for (int k = 0; k < int'(NREQ); k++) begin
        if (!req_vld[k] && $urandom_range(0, 99) < 35) begin
          din_v = ($urandom_range(0, 3) == 0) ? 32'h3FC + $urandom_range(0, 3)
                                              : $urandom_range(0, (1 << DW_IN) - 1);
          set_din(k, din_v);
          req_vld[k] = 1'b1;
        end
      end
      rdy = ($urandom_range(0, 99) < 70);
      #1;
      w   = ref_pick(req_vld, m_ptr);
      can = !m_vld || rdy;
      acc = (w >= 0) && can;
      chk("rs_req_rdy", 32'(req_rdy), acc ? (32'd1 << w) : 0);
      if (vld && rdy) begin
        chk("sb_nonempty", 32'(sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("sb_id", 32'(id), e.id);
          chk("sb_dout", 32'(dout), e.dout);
          chk("sb_ovf", 32'(ovf), e.ovf);
        end
      end
      if (acc) begin
        ref_round(32'(req_din[w*DW_IN +: DW_IN]), ed, eo);
        m_ptr = w; m_vld = 1; m_dout = ed; m_ovf = eo; m_id = 32'(w);
        sbq.push_back('{32'(w), ed, eo});
      end else if (rdy) begin
        m_vld = 0;
      end
      tick();
      if (acc) req_vld[w] = 1'b0;
    end
    chk("sb_left", 32'(sbq.size()), m_vld ? 1 : 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
